// File: rtl/vic_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM states, request-number width,
// reset vector base and the vector address helper.
package vic_pkg;

    localparam int VIC_NUM_IRQ = 31;
    localparam int VIC_ADDR_W  = 5;
    localparam logic [31:0] VIC_VEC_BASE_RST = 32'h0000_0100;

    // The one address above the valid range marks a spurious request.
    localparam logic [VIC_ADDR_W-1:0] VIC_SPUR_ADDR = VIC_ADDR_W'(VIC_NUM_IRQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PENDING,
        ST_ENTRY,
        ST_SERVICE,
        ST_EXIT
    } state_t;

    // Vector slots are one 32-bit word apart; the sum wraps modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [VIC_ADDR_W-1:0] num);
        return base + {{(30 - VIC_ADDR_W){1'b0}}, num, 2'b00};
    endfunction

endpackage

// File: rtl/irq_dispatch_if.sv
// Bundle of the controller/CPU-facing signals of irq_dispatch plus a debug view of the FSM state.
interface irq_dispatch_if;
    import vic_pkg::*;

    // Handshake: i_irq_req is a valid-only strobe (no ready); i_irq_addr is valid whenever
    // i_irq_req is high and is sampled at every rising edge. o_take and o_ret are one-cycle strobes.
    logic                  i_irq_req;
    logic [VIC_ADDR_W-1:0] i_irq_addr;
    logic                  i_gie;
    logic                  i_instr_done;
    logic [31:0]           i_pc;
    logic                  i_reti;
    logic                  i_base_we;
    logic [31:0]           i_base;

    logic                  o_in_service;
    logic [VIC_ADDR_W-1:0] o_irq_num;
    logic                  o_take;
    logic [31:0]           o_vector_pc;
    logic                  o_ret;
    logic [31:0]           o_ret_pc;
    logic                  o_overrun;
    logic                  o_spurious;
    state_t                o_state;

    modport master (
        output i_irq_req, i_irq_addr, i_gie, i_instr_done, i_pc, i_reti, i_base_we, i_base,
        input  o_in_service, o_irq_num, o_take, o_vector_pc, o_ret, o_ret_pc,
               o_overrun, o_spurious, o_state
    );

    modport slave (
        input  i_irq_req, i_irq_addr, i_gie, i_instr_done, i_pc, i_reti, i_base_we, i_base,
        output o_in_service, o_irq_num, o_take, o_vector_pc, o_ret, o_ret_pc,
               o_overrun, o_spurious, o_state
    );

endinterface

// File: rtl/irq_pend_slot.sv
// One-deep pending-request latch. A push into a full slot that is not being popped
// is dropped and raises the sticky overrun flag.
module irq_pend_slot
    import vic_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [VIC_ADDR_W-1:0] push_addr_i,
    input  logic                  pop_i,
    output logic                  valid_nxt_o,
    output logic [VIC_ADDR_W-1:0] addr_o,
    output logic                  overrun_o
);

    logic                  valid_q, valid_d;
    logic [VIC_ADDR_W-1:0] addr_q, addr_d;
    logic                  overrun_q, overrun_d;

    // Pop takes effect first, so a push in the consuming cycle refills the slot.
    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        overrun_d = overrun_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            if (valid_q && !pop_i) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                addr_d  = push_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_nxt_o = valid_d;
    assign addr_o      = addr_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: waits for an instruction boundary with interrupts enabled,
// redirects the CPU to the vector table entry and returns to the saved PC on reti.
module irq_dispatch
    import vic_pkg::*;
#(
    parameter logic [31:0] VEC_BASE_RST = VIC_VEC_BASE_RST
) (
    input  logic         i_clk,
    input  logic         i_rst,
    irq_dispatch_if.slave bus
);

    state_t                state_q, state_d;
    logic [31:0]           base_q;
    logic [31:0]           saved_pc_q;
    logic [VIC_ADDR_W-1:0] irq_num_q;
    logic                  in_service_q;
    logic                  spurious_q;

    logic                  req_spur;
    logic                  req_ok;
    logic                  pop;
    logic                  slot_valid_nxt;
    logic [VIC_ADDR_W-1:0] slot_addr;
    logic                  overrun;

    assign req_spur = bus.i_irq_req && (bus.i_irq_addr == VIC_SPUR_ADDR);
    assign req_ok   = bus.i_irq_req && !req_spur;
    assign pop      = (state_q == ST_PENDING) && bus.i_gie && bus.i_instr_done;

    irq_pend_slot u_slot (
        .clk_i       (i_clk),
        .rst_ni      (i_rst),
        .push_i      (req_ok),
        .push_addr_i (bus.i_irq_addr),
        .pop_i       (pop),
        .valid_nxt_o (slot_valid_nxt),
        .addr_o      (slot_addr),
        .overrun_o   (overrun)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (slot_valid_nxt) state_d = ST_PENDING;
            ST_PENDING: if (pop) state_d = ST_ENTRY;
            ST_ENTRY:   state_d = ST_SERVICE;
            ST_SERVICE: if (bus.i_reti) state_d = ST_EXIT;
            // A request accepted during EXIT itself must still be picked up.
            ST_EXIT:    state_d = slot_valid_nxt ? ST_PENDING : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            base_q       <= VEC_BASE_RST;
            saved_pc_q   <= '0;
            irq_num_q    <= '0;
            in_service_q <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_service_q <= (state_d == ST_ENTRY) || (state_d == ST_SERVICE);
            if (pop) begin
                irq_num_q <= slot_addr;
            end
            if (state_q == ST_ENTRY) begin
                saved_pc_q <= bus.i_pc;
            end
            if (bus.i_base_we) begin
                base_q <= bus.i_base;
            end
            if (req_spur) begin
                spurious_q <= 1'b1;
            end
        end
    end

    // The vector is formed from the registered base, so a base write in ENTRY lands afterwards.
    assign bus.o_take       = (state_q == ST_ENTRY);
    assign bus.o_vector_pc  = bus.o_take ? vec_addr(base_q, irq_num_q) : '0;
    assign bus.o_ret        = (state_q == ST_EXIT);
    assign bus.o_ret_pc     = bus.o_ret ? saved_pc_q : '0;
    assign bus.o_in_service = in_service_q;
    assign bus.o_irq_num    = irq_num_q;
    assign bus.o_overrun    = overrun;
    assign bus.o_spurious   = spurious_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios with a scoreboard of
// expected take/return events checked by a negedge monitor.
module tb_irq_dispatch;
    import vic_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Scoreboard entry: {is_take, irq_num, pc}
    logic [37:0] exp_q[$];

    irq_dispatch_if bus ();

    irq_dispatch #(.VEC_BASE_RST(32'h0000_0100)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_vec(input logic [31:0] base, input int num);
        return base + 32'(num * 4);
    endfunction

    task automatic push_take(input int num, input logic [31:0] base);
        exp_q.push_back({1'b1, 5'(num), model_vec(base, num)});
    endtask

    task automatic push_ret(input logic [31:0] pc);
        exp_q.push_back({1'b0, 5'd0, pc});
    endtask

    task automatic request(input int num);
        bus.i_irq_req  = 1'b1;
        bus.i_irq_addr = 5'(num);
        step();
        bus.i_irq_req  = 1'b0;
        bus.i_irq_addr = '0;
    endtask

    // Called in the ENTRY cycle; walks SERVICE -> EXIT -> next state.
    task automatic serve_and_return(input logic [31:0] pc);
        step();
        bus.i_base_we = 1'b0;
        check_eq("in_service_svc", 64'(bus.o_in_service), 64'd1);
        check_eq("state_svc", 64'(bus.o_state), 64'(ST_SERVICE));
        bus.i_reti = 1'b1;
        push_ret(pc);
        step();
        bus.i_reti = 1'b0;
        check_eq("ret_pulse", 64'(bus.o_ret), 64'd1);
        check_eq("in_service_exit", 64'(bus.o_in_service), 64'd0);
        step();
        check_eq("ret_single", 64'(bus.o_ret), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst_n && (bus.o_take || bus.o_ret)) begin
            check_eq("take_ret_excl", 64'(bus.o_take && bus.o_ret), 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexp_out", 64'({bus.o_take, bus.o_ret}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_kind", 64'(bus.o_take), 64'(e[37]));
                if (e[37]) begin
                    check_eq("vector_pc", 64'(bus.o_vector_pc), 64'(e[31:0]));
                    check_eq("irq_num", 64'(bus.o_irq_num), 64'(e[36:32]));
                end else begin
                    check_eq("ret_pc", 64'(bus.o_ret_pc), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_irq_req = 1'b0; bus.i_irq_addr = '0; bus.i_gie = 1'b0;
        bus.i_instr_done = 1'b0; bus.i_pc = '0; bus.i_reti = 1'b0;
        bus.i_base_we = 1'b0; bus.i_base = '0;
        repeat (3) step();

        check_eq("rst_in_service", 64'(bus.o_in_service), 64'd0);
        check_eq("rst_take", 64'(bus.o_take), 64'd0);
        check_eq("rst_ret", 64'(bus.o_ret), 64'd0);
        check_eq("rst_overrun", 64'(bus.o_overrun), 64'd0);
        check_eq("rst_spurious", 64'(bus.o_spurious), 64'd0);
        check_eq("rst_irq_num", 64'(bus.o_irq_num), 64'd0);
        check_eq("rst_state", 64'(bus.o_state), 64'(ST_IDLE));

        // Basic take with minimum latency, then return
        rst_n = 1'b1; bus.i_gie = 1'b1; bus.i_instr_done = 1'b1; bus.i_pc = 32'h2000;
        step();
        push_take(5, 32'h100);
        request(5);
        check_eq("lat_pending", 64'(bus.o_state), 64'(ST_PENDING));
        step();
        check_eq("take_5", 64'(bus.o_take), 64'd1);
        check_eq("in_service_entry", 64'(bus.o_in_service), 64'd1);
        check_eq("irq_num_5", 64'(bus.o_irq_num), 64'd5);
        serve_and_return(32'h2000);
        check_eq("idle_after_ret", 64'(bus.o_state), 64'(ST_IDLE));

        // Request held while gie is low
        bus.i_gie = 1'b0; bus.i_pc = 32'h3000;
        push_take(3, 32'h100);
        request(3);
        repeat (10) step();
        check_eq("held_no_take", 64'(bus.o_take), 64'd0);
        check_eq("held_pending", 64'(bus.o_state), 64'(ST_PENDING));
        bus.i_gie = 1'b1; bus.i_instr_done = 1'b0;
        step();
        check_eq("no_boundary_no_take", 64'(bus.o_take), 64'd0);
        bus.i_instr_done = 1'b1;
        step();
        check_eq("take_3", 64'(bus.o_take), 64'd1);
        serve_and_return(32'h3000);

        // Overrun: second request during SERVICE dropped, first one served after EXIT
        bus.i_pc = 32'h4000;
        push_take(2, 32'h100);
        request(2);
        step();
        step();
        request(7);
        request(9);
        check_eq("overrun", 64'(bus.o_overrun), 64'd1);
        bus.i_reti = 1'b1;
        push_ret(32'h4000);
        push_take(7, 32'h100);
        step();
        bus.i_reti = 1'b0;
        check_eq("ret_overrun", 64'(bus.o_ret), 64'd1);
        step();
        check_eq("pending_after_exit", 64'(bus.o_state), 64'(ST_PENDING));
        step();
        check_eq("take_7", 64'(bus.o_take), 64'd1);
        serve_and_return(32'h4000);

        // Request and reti in the same SERVICE cycle
        bus.i_pc = 32'h5000;
        push_take(4, 32'h100);
        request(4);
        step();
        step();
        bus.i_irq_req = 1'b1; bus.i_irq_addr = 5'd6; bus.i_reti = 1'b1;
        push_ret(32'h5000);
        push_take(6, 32'h100);
        step();
        bus.i_irq_req = 1'b0; bus.i_reti = 1'b0;
        step();
        step();
        check_eq("take_6", 64'(bus.o_take), 64'd1);
        serve_and_return(32'h5000);

        // Spurious request and base wrap
        request(31);
        check_eq("spurious", 64'(bus.o_spurious), 64'd1);
        check_eq("spur_idle", 64'(bus.o_state), 64'(ST_IDLE));
        step();
        check_eq("spur_no_take", 64'(bus.o_take), 64'd0);
        bus.i_base_we = 1'b1; bus.i_base = 32'hFFFF_FFFC;
        step();
        bus.i_base_we = 1'b0;
        push_take(1, 32'hFFFF_FFFC);
        request(1);
        step();
        check_eq("take_wrap", 64'(bus.o_take), 64'd1);
        // Base write in ENTRY must not affect this vector
        bus.i_base_we = 1'b1; bus.i_base = 32'h0000_0200;
        serve_and_return(32'h5000);

        // Reset in SERVICE with a latched request; inputs ignored during reset
        bus.i_pc = 32'h6000;
        push_take(10, 32'h200);
        request(10);
        step();
        step();
        request(11);
        rst_n = 1'b0; bus.i_irq_req = 1'b1; bus.i_irq_addr = 5'd12; bus.i_reti = 1'b1;
        step();
        check_eq("rst_drop_service", 64'(bus.o_in_service), 64'd0);
        check_eq("rst_no_ret", 64'(bus.o_ret), 64'd0);
        check_eq("rst_state_idle", 64'(bus.o_state), 64'(ST_IDLE));
        check_eq("rst_clr_overrun", 64'(bus.o_overrun), 64'd0);
        check_eq("rst_clr_spurious", 64'(bus.o_spurious), 64'd0);
        rst_n = 1'b1; bus.i_irq_req = 1'b0; bus.i_irq_addr = '0; bus.i_reti = 1'b0;
        step();
        step();
        check_eq("discarded_idle", 64'(bus.o_state), 64'(ST_IDLE));
        check_eq("discarded_no_take", 64'(bus.o_take), 64'd0);
        push_take(5, 32'h100);
        request(5);
        step();
        check_eq("take_base_rst", 64'(bus.o_take), 64'd1);
        serve_and_return(32'h6000);

        step();
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have parameter VEC_BASE_RST, default 32'h0000_0100, reset value of vector table base.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have i_rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have i_irq_req  in  1  interrupt request from controller, sampled high at posedge; i_irq_addr  in  5  request number 0..30, valid with i_irq_req.
REQ-005 SHALL have i_gie  in  1  CPU global interrupt enable; i_instr_done  in  1  instruction boundary strobe; i_pc  in  32  next-sequential PC.
REQ-006 SHALL have i_reti  in  1  return-from-interrupt executed; i_base_we  in  1  and i_base  in  32  base register write.
REQ-007 SHALL have o_in_service  out  1  to controller i_IRQ, falling edge = handler done; o_irq_num  out  5  number being serviced.
REQ-008 SHALL have o_take  out  1  redirect strobe; o_vector_pc  out  32; o_ret  out  1; o_ret_pc  out  32; o_overrun  out  1  sticky; o_spurious  out  1  sticky.

Function
REQ-009 SHALL implement FSM IDLE, PENDING, ENTRY, SERVICE, EXIT.
REQ-010 IDLE: i_irq_req with addr 0..30 -> latch addr, next state PENDING; addr 31 -> set o_spurious, stay IDLE.
REQ-011 PENDING -> ENTRY when i_gie && i_instr_done in same cycle; otherwise hold, request retained indefinitely.
REQ-012 ENTRY: exactly one cycle; o_take=1; o_vector_pc = base + {addr,2'b00} (32-bit, wrap mod 2^32); saved_pc <= i_pc; o_irq_num <= addr.
REQ-013 o_in_service SHALL be registered, high in ENTRY and SERVICE, low in all other states.
REQ-014 SERVICE -> EXIT on i_reti; i_reti in any other state ignored.
REQ-015 EXIT: exactly one cycle; o_ret=1; o_ret_pc=saved_pc; o_in_service=0; next PENDING if a request is latched, else IDLE.
REQ-016 Request while not IDLE: if pending slot empty, latch it (served after EXIT); if full, first request kept, new dropped, o_overrun set.
REQ-017 Request and i_reti in same SERVICE cycle: both take effect; EXIT then goes to PENDING.
REQ-018 i_base_we SHALL update base next cycle; a write coinciding with ENTRY uses old base.
REQ-019 Latency i_irq_req -> o_take SHALL be 2 cycles minimum (IDLE->PENDING->ENTRY) with gie and instr_done high.
REQ-020 o_take, o_ret SHALL be single-cycle pulses, never simultaneously high.
REQ-021 o_overrun, o_spurious SHALL clear only on reset.

Reset
REQ-022 i_rst=0 at posedge SHALL force: state IDLE, pending clear, base=VEC_BASE_RST, saved_pc=0, all outputs 0.
REQ-023 Reset during SERVICE SHALL drop o_in_service next cycle with no o_ret; latched request discarded.
REQ-024 Inputs SHALL be ignored in the cycle reset is asserted.

Structure
REQ-025 Shared package vic_pkg SHALL hold state enum, VIC_NUM_IRQ=31, VIC_ADDR_W=5, VEC_BASE_RST default.
REQ-026 Pending-request latch with overrun detection SHALL be sub-module irq_pend_slot; FSM and vector arithmetic in top.

Verification
REQ-027 Reset, i_irq_req=1 addr=5, gie=1, instr_done=1 -> o_take 2 cycles later, o_vector_pc=32'h114, o_in_service=1, o_irq_num=5.
REQ-028 In SERVICE with i_pc=32'h2000 captured, pulse i_reti -> next cycle o_ret=1, o_ret_pc=32'h2000, o_in_service=0, state IDLE.
REQ-029 Request addr=3 with gie=0 for 10 cycles then gie=1 -> o_take on first instr_done after, vector 32'h10C.
REQ-030 In SERVICE, request 7 then request 9 -> o_overrun=1, after EXIT second ENTRY uses addr 7.
REQ-031 Request addr=31 -> o_spurious=1, no o_take; base write 32'hFFFF_FFFC then addr=1 -> vector 32'h0000_0000.
REQ-032 Assert i_rst=0 mid-SERVICE -> o_in_service 0 next cycle, o_ret stays 0, base back to 32'h100.
